trace_checker: RTL and testbench

//  Consumer end of the CPU writeback debug-trace interface (debug_wb_*).

---
 rtl/trace_checker_pkg.sv | 25 ++
 rtl/trace_checker_fifo.sv | 58 +++++
 rtl/trace_checker.sv | 173 +++++++++++++++++
 tb/tb_trace_checker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_checker_pkg.sv
// Shared types for the writeback trace checker: entry layout, FSM encoding, byte mask.
package trace_checker_pkg;

  localparam int TRACE_ENTRY_WD = 73;  // 32 pc + 4 wen + 5 wnum + 32 wdata

  typedef enum logic [1:0] {
    TC_RUN   = 2'd0,
    TC_DRAIN = 2'd1,
    TC_ERROR = 2'd2,
    TC_DONE  = 2'd3
  } tc_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_entry_t;

  // Expand per-byte write enables into a 32-bit data mask.
  function automatic logic [31:0] wen_mask(input logic [3:0] wen);
    return {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
  endfunction

endpackage

// File: rtl/trace_checker_fifo.sv
// Synchronous FIFO for captured writebacks. Pointers carry one extra wrap bit so
// full/empty fall out of a plain compare; push while full is accepted only when
// a pop happens in the same cycle.
module trace_fifo
  import trace_checker_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = TRACE_ENTRY_WD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem_q[rptr_q[AW-1:0]];

  // Advance pointers on accepted push/pop; natural wrap through the extra bit.
  always_comb begin
    wptr_d = wptr_q + (AW+1)'(push_ok);
    rptr_d = rptr_q + (AW+1)'(pop_ok);
  end

  // Pointer registers; clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/trace_checker.sv
// Writeback trace checker: buffers retired register writes and compares them in
// order against a golden trace, reporting first mismatch, overflow and pass/fail.
module trace_checker
  import trace_checker_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] END_PC     = 32'hbfc00100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] debug_wb_pc,
  input  logic [3:0]  debug_wb_rf_wen,
  input  logic [4:0]  debug_wb_rf_wnum,
  input  logic [31:0] debug_wb_rf_wdata,
  input  logic        ref_valid,
  output logic        ref_ready,
  input  logic [31:0] ref_pc,
  input  logic [4:0]  ref_wnum,
  input  logic [31:0] ref_wdata,
  output logic        err,
  output logic        err_overflow,
  output logic [31:0] err_pc,
  output logic [31:0] err_wdata_dut,
  output logic [31:0] err_wdata_ref,
  output logic [31:0] match_cnt,
  output logic        done,
  output logic        pass
);

  tc_state_e   state_q, state_d;
  logic        err_q, err_d;
  logic        err_overflow_q, err_overflow_d;
  logic [31:0] err_pc_q, err_pc_d;
  logic [31:0] err_wdata_dut_q, err_wdata_dut_d;
  logic [31:0] err_wdata_ref_q, err_wdata_ref_d;
  logic [31:0] match_cnt_q, match_cnt_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  trace_entry_t                wb_entry;
  trace_entry_t                head;
  logic [TRACE_ENTRY_WD-1:0]   head_bits;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        capture_ev;
  logic                        push;
  logic                        pop;
  logic                        overflow;
  logic                        mismatch;
  logic [31:0]                 head_mask;
  logic [31:0]                 wb_mask;

  assign capture_ev = (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
  assign wb_entry   = '{pc: debug_wb_pc, wen: debug_wb_rf_wen,
                        wnum: debug_wb_rf_wnum, wdata: debug_wb_rf_wdata};
  assign head       = trace_entry_t'(head_bits);
  assign head_mask  = wen_mask(head.wen);
  assign wb_mask    = wen_mask(debug_wb_rf_wen);

  // Golden entries are accepted only while comparing is still meaningful.
  assign ref_ready  = ((state_q == TC_RUN) || (state_q == TC_DRAIN)) && !fifo_empty;
  assign pop        = ref_valid & ref_ready;
  assign mismatch   = pop && ((head.pc != ref_pc) || (head.wnum != ref_wnum) ||
                              ((head.wdata & head_mask) != (ref_wdata & head_mask)));
  // A pop in the same cycle frees a slot, so full alone is not an overflow.
  assign overflow   = (state_q == TC_RUN) && capture_ev && fifo_full && !pop;
  assign push       = (state_q == TC_RUN) && capture_ev && !overflow;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TRACE_ENTRY_WD)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (wb_entry),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state: compare result, sticky error capture, match counter and FSM.
  always_comb begin
    state_d         = state_q;
    err_d           = err_q;
    err_overflow_d  = err_overflow_q;
    err_pc_d        = err_pc_q;
    err_wdata_dut_d = err_wdata_dut_q;
    err_wdata_ref_d = err_wdata_ref_q;
    match_cnt_d     = match_cnt_q;
    done_d          = done_q;

    if (pop && !mismatch && (match_cnt_q != 32'hffff_ffff)) begin
      match_cnt_d = match_cnt_q + 32'd1;
    end

    // Error capture happens only from RUN/DRAIN, so it is naturally latched once.
    if (mismatch) begin
      err_d           = 1'b1;
      err_pc_d        = head.pc;
      err_wdata_dut_d = head.wdata & head_mask;
      err_wdata_ref_d = ref_wdata & head_mask;
    end else if (overflow) begin
      err_d           = 1'b1;
      err_pc_d        = debug_wb_pc;
      err_wdata_dut_d = debug_wb_rf_wdata & wb_mask;
      err_wdata_ref_d = 32'd0;
    end
    if (overflow) begin
      err_overflow_d = 1'b1;
    end

    unique case (state_q)
      TC_RUN: begin
        if (mismatch || overflow)        state_d = TC_ERROR;
        else if (debug_wb_pc == END_PC)  state_d = TC_DRAIN;
      end
      TC_DRAIN: begin
        if (mismatch) begin
          state_d = TC_ERROR;
        end else if (fifo_empty) begin
          state_d = TC_DONE;
          done_d  = 1'b1;
        end
      end
      TC_ERROR: begin
        if (debug_wb_pc == END_PC) done_d = 1'b1;
      end
      TC_DONE: begin
        done_d = 1'b1;
      end
      default: state_d = TC_RUN;
    endcase

    pass_d = done_d & ~err_d;
  end

  // Single register bank for FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= TC_RUN;
      err_q           <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_pc_q        <= 32'd0;
      err_wdata_dut_q <= 32'd0;
      err_wdata_ref_q <= 32'd0;
      match_cnt_q     <= 32'd0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      err_q           <= err_d;
      err_overflow_q  <= err_overflow_d;
      err_pc_q        <= err_pc_d;
      err_wdata_dut_q <= err_wdata_dut_d;
      err_wdata_ref_q <= err_wdata_ref_d;
      match_cnt_q     <= match_cnt_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign err           = err_q;
  assign err_overflow  = err_overflow_q;
  assign err_pc        = err_pc_q;
  assign err_wdata_dut = err_wdata_dut_q;
  assign err_wdata_ref = err_wdata_ref_q;
  assign match_cnt     = match_cnt_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed + randomized bench for trace_checker against a queue-based reference model.
module tb_trace_checker;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] END_PC = 32'hbfc00100;

  logic        clk;
  logic        reset;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        ref_valid;
  logic        ref_ready;
  logic [31:0] ref_pc;
  logic [4:0]  ref_wnum;
  logic [31:0] ref_wdata;
  logic        err;
  logic        err_overflow;
  logic [31:0] err_pc;
  logic [31:0] err_wdata_dut;
  logic [31:0] err_wdata_ref;
  logic [31:0] match_cnt;
  logic        done;
  logic        pass;

  trace_checker #(.FIFO_DEPTH(DEPTH), .END_PC(END_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .ref_valid         (ref_valid),
    .ref_ready         (ref_ready),
    .ref_pc            (ref_pc),
    .ref_wnum          (ref_wnum),
    .ref_wdata         (ref_wdata),
    .err               (err),
    .err_overflow      (err_overflow),
    .err_pc            (err_pc),
    .err_wdata_dut     (err_wdata_dut),
    .err_wdata_ref     (err_wdata_ref),
    .match_cnt         (match_cnt),
    .done              (done),
    .pass              (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  wen;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } gold_t;

  // Reference model: captured entries, golden stream, and the externally visible facts.
  ent_t        mq[$];
  gold_t       gq[$];
  bit          m_err, m_ovf, m_end, m_done;
  logic [31:0] m_pc, m_dut, m_ref, m_cnt;
  logic [31:0] g_wdata;
  bit          rv_en;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [31:0] bmask(input logic [3:0] wen);
    logic [31:0] m;
    m = 32'd0;
    for (int b = 0; b < 4; b++) if (wen[b]) m[8*b +: 8] = 8'hff;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    gq.delete();
    m_err = 0; m_ovf = 0; m_end = 0; m_done = 0;
    m_pc = 0; m_dut = 0; m_ref = 0; m_cnt = 0;
  endtask

  // One clock: drive golden side, predict, clock, compare every output.
  task automatic cycle();
    bit   rdy, pop, ev, mis;
    bit   err0, end0, done0;
    int   sz0;
    ent_t e;
    logic [31:0] m;
    if (rv_en && gq.size() > 0) begin
      ref_valid = 1'b1;
      ref_pc    = gq[0].pc;
      ref_wnum  = gq[0].wnum;
      ref_wdata = gq[0].wdata;
    end else begin
      ref_valid = 1'b0;
      ref_pc    = $urandom;
      ref_wnum  = 5'($urandom);
      ref_wdata = $urandom;
    end
    #1;
    sz0 = mq.size(); err0 = m_err; end0 = m_end; done0 = m_done;
    rdy = !err0 && !done0 && (sz0 > 0);
    chk("ref_ready", 32'(ref_ready), 32'(rdy));
    if (reset) begin
      model_clear();
    end else begin
      ev  = (debug_wb_rf_wen != 0) && (debug_wb_rf_wnum != 0);
      pop = ref_valid && rdy;
      mis = 0;
      if (pop) begin
        e = mq.pop_front();
        gq.delete(0);
        m = bmask(e.wen);
        mis = (e.pc != ref_pc) || (e.wnum != ref_wnum) || ((e.wdata & m) != (ref_wdata & m));
        if (mis) begin
          m_err = 1; m_pc = e.pc; m_dut = e.wdata & m; m_ref = ref_wdata & m;
        end else if (m_cnt != 32'hffffffff) begin
          m_cnt = m_cnt + 1;
        end
      end
      if (!err0 && !end0 && ev) begin
        if (sz0 == DEPTH && !pop) begin
          m_ovf = 1;
          m_err = 1;
          if (!mis) begin
            m_pc = debug_wb_pc; m_dut = debug_wb_rf_wdata & bmask(debug_wb_rf_wen); m_ref = 0;
          end
        end else begin
          mq.push_back('{debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata});
          gq.push_back('{debug_wb_pc, debug_wb_rf_wnum, g_wdata});
        end
      end
      if (!err0 && !end0 && !m_err && debug_wb_pc == END_PC) m_end = 1;
      if (err0 && debug_wb_pc == END_PC) m_done = 1;
      if (!err0 && end0 && !done0 && sz0 == 0) m_done = 1;
    end
    @(posedge clk);
    #1;
    chk("err", 32'(err), 32'(m_err));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
    chk("err_pc", err_pc, m_pc);
    chk("err_wdata_dut", err_wdata_dut, m_dut);
    chk("err_wdata_ref", err_wdata_ref, m_ref);
    chk("match_cnt", match_cnt, m_cnt);
    chk("done", 32'(done), 32'(m_done));
    chk("pass", 32'(pass), 32'(m_done && !m_err));
  endtask

  task automatic ev_step(input logic [31:0] pc, input logic [3:0] wen, input logic [4:0] wnum,
                         input logic [31:0] wdata, input logic [31:0] gwdata);
    debug_wb_pc = pc; debug_wb_rf_wen = wen; debug_wb_rf_wnum = wnum;
    debug_wb_rf_wdata = wdata; g_wdata = gwdata;
    cycle();
  endtask

  task automatic idle_step(input int n);
    for (int k = 0; k < n; k++) ev_step(32'h0000_1000, 4'h0, 5'd0, $urandom, 32'd0);
  endtask

  task automatic end_step();
    ev_step(END_PC, 4'h0, 5'd0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_step(1);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w, g, m;
    logic [3:0]  wn;
    logic [4:0]  n;
    reset = 1'b0; rv_en = 1'b0; g_wdata = 0;
    debug_wb_pc = 0; debug_wb_rf_wen = 0; debug_wb_rf_wnum = 0; debug_wb_rf_wdata = 0;
    ref_valid = 0; ref_pc = 0; ref_wnum = 0; ref_wdata = 0;
    model_clear();

    // Reset state
    do_reset();
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_match_cnt", match_cnt, 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // 1: lockstep then END_PC
    rv_en = 1;
    for (int i = 0; i < 5; i++) begin
      w = $urandom; n = 5'($urandom_range(1, 31));
      ev_step(32'hbfc00000 + 32'(4 * i), 4'hf, n, w, w);
    end
    idle_step(2);
    end_step();
    idle_step(3);
    chk("t1_match_cnt", match_cnt, 32'd5);
    chk("t1_pass", 32'(pass), 32'd1);

    // 2: data mismatch on third entry
    do_reset();
    rv_en = 1;
    for (int i = 0; i < 5; i++) begin
      w = (i == 2) ? 32'h12345678 : $urandom;
      g = (i == 2) ? 32'h12345679 : w;
      ev_step(32'hbfc00000 + 32'(4 * i), 4'hf, 5'd2, w, g);
      if (i == 2) chk("t2_err_early", 32'(err), 32'd0);
      if (i == 3) begin
        chk("t2_err", 32'(err), 32'd1);
        chk("t2_err_pc", err_pc, 32'hbfc00008);
        chk("t2_match_cnt", match_cnt, 32'd2);
      end
    end
    idle_step(2);
    chk("t2_ready_low", 32'(ref_ready), 32'd0);
    chk("t2_dut_data", err_wdata_dut, 32'h12345678);
    chk("t2_ref_data", err_wdata_ref, 32'h12345679);

    // 3: byte mask and non-events
    do_reset();
    rv_en = 1;
    w = $urandom;
    ev_step(32'hbfc00000, 4'hf, 5'd3, w, w);
    ev_step(32'hbfc00004, 4'b0011, 5'd4, 32'hAAAA1234, 32'h55551234);
    ev_step(32'hbfc00008, 4'h0, 5'd5, $urandom, 32'd0);
    ev_step(32'hbfc0000c, 4'hf, 5'd0, $urandom, 32'd0);
    w = $urandom;
    ev_step(32'hbfc00010, 4'b1000, 5'd7, w, w ^ 32'h00ffffff);
    idle_step(2);
    chk("t3_match_cnt", match_cnt, 32'd3);
    chk("t3_err", 32'(err), 32'd0);
    end_step();
    idle_step(2);
    chk("t3_pass", 32'(pass), 32'd1);

    // 4: overflow under backpressure
    do_reset();
    rv_en = 0;
    for (int i = 0; i < 12; i++) begin
      w = $urandom;
      ev_step(32'hbfc00000 + 32'(4 * i), 4'hf, 5'd9, w, w);
      if (i == 7) chk("t4_no_err_yet", 32'(err), 32'd0);
      if (i == 8) begin
        chk("t4_overflow", 32'(err_overflow), 32'd1);
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_err_pc", err_pc, 32'hbfc00020);
      end
    end
    // 4b: full FIFO with same-cycle pop is legal
    do_reset();
    rv_en = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 8) rv_en = 1;
      w = $urandom;
      ev_step(32'hbfc00000 + 32'(4 * i), 4'hf, 5'd10, w, w);
      if (i == 8) chk("t4b_no_overflow", 32'(err_overflow), 32'd0);
    end
    idle_step(3);
    end_step();
    idle_step(10);
    chk("t4b_match_cnt", match_cnt, 32'd11);
    chk("t4b_pass", 32'(pass), 32'd1);

    // 5: END_PC with three buffered entries, golden arrives late
    do_reset();
    rv_en = 0;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      ev_step(32'hbfc00000 + 32'(4 * i), 4'hf, 5'd11, w, w);
    end
    end_step();
    idle_step(2);
    ev_step(32'hbfc00040, 4'hf, 5'd12, $urandom, 32'd0);
    rv_en = 1;
    idle_step(6);
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_match_cnt", match_cnt, 32'd3);
    ev_step(32'hbfc00044, 4'hf, 5'd13, $urandom, 32'd0);
    idle_step(2);
    chk("t5_pass", 32'(pass), 32'd1);

    // 6: reset mid-stream, then a fresh stream
    do_reset();
    rv_en = 0;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      ev_step(32'hbfc00000 + 32'(4 * i), 4'hf, 5'd14, w, w);
    end
    rv_en = 1;
    reset = 1'b1;
    idle_step(1);
    reset = 1'b0;
    chk("t6_err", 32'(err), 32'd0);
    chk("t6_match_cnt", match_cnt, 32'd0);
    idle_step(1);
    chk("t6_ready", 32'(ref_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      ev_step(32'hbfc00000 + 32'(4 * i), 4'hf, 5'd15, w, w);
    end
    idle_step(2);
    end_step();
    idle_step(3);
    chk("t6_pass", 32'(pass), 32'd1);

    // Randomized stream against the model
    do_reset();
    for (int i = 0; i < 80; i++) begin
      rv_en = ($urandom_range(0, 9) < 7);
      wn = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      n  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      w  = $urandom;
      m  = bmask(wn);
      g  = (w & m) | ($urandom & ~m);
      if ($urandom_range(0, 59) == 0) g = g ^ (m & 32'h0101_0101);
      ev_step(32'h8000_0000 + 32'(4 * i), wn, n, w, g);
    end
    rv_en = 1;
    end_step();
    idle_step(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
